// File: rtl/muntjac_fetch_pkg.sv
// rtl/muntjac_fetch_pkg.sv - shared types for the fetch/decode boundary
//
// fetched_instr_t: one fetched instruction as handed from frontend to backend.
//   pc       : address of the instruction
//   instr    : raw instruction bits
//   ex_valid : fetch raised an exception for this entry
//   ex_cause : exception cause code, meaningful only when ex_valid is set

package muntjac_fetch_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        ex_valid;
    logic [3:0]  ex_cause;
  } fetched_instr_t;

endpackage

// File: rtl/muntjac_fetch_buffer.sv
// rtl/muntjac_fetch_buffer.sv - in-order instruction queue between fetch and decode
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      drop every buffered entry (backend redirect)
//   in_valid_i   frontend offers in_instr_i
//   in_ready_o   buffer has a free slot (depends only on occupancy)
//   in_instr_i   instruction from the frontend
//   out_valid_o  head entry present
//   out_ready_i  backend takes the head entry
//   out_instr_o  head entry
//   count_o      occupancy, 0..Depth
//   starve_o     registered pulse: backend was ready while the buffer was empty

module muntjac_fetch_buffer
  import muntjac_fetch_pkg::*;
#(
  parameter int unsigned  Depth = 4,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  fetched_instr_t  in_instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output fetched_instr_t  out_instr_o,
  output logic [CntW-1:0] count_o,
  output logic            starve_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetched_instr_t  mem [Depth];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  logic [CntW-1:0] cnt;
  logic            starve_q;
  logic            push;
  logic            pop;

  // Ready is a pure function of occupancy, so a full buffer stays not-ready
  // during a pop cycle; this keeps out_ready_i off the in_ready_o path.
  assign in_ready_o  = (cnt != CntW'(Depth));
  assign out_valid_o = (cnt != '0);
  assign out_instr_o = mem[rd_ptr];
  assign count_o     = cnt;
  assign starve_o    = starve_q;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      starve_q <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
    end else begin
      starve_q <= out_ready_i && !out_valid_o && !flush_i;
      if (flush_i) begin
        // Storage is left as is; only the bookkeeping is cleared.
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_instr_i;
          wr_ptr      <= wr_ptr + PtrW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PtrW'(1);
        end
        if (push && !pop) begin
          cnt <= cnt + CntW'(1);
        end else if (pop && !push) begin
          cnt <= cnt - CntW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_muntjac_fetch_buffer.sv
// tb/tb_muntjac_fetch_buffer.sv - directed self-checking bench for muntjac_fetch_buffer

module tb_muntjac_fetch_buffer;
  import muntjac_fetch_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  fetched_instr_t in_instr;
  logic           out_valid;
  logic           out_ready;
  fetched_instr_t out_instr;
  logic [2:0]     count;
  logic           starve;

  int passed;
  int total;

  muntjac_fetch_buffer #(.Depth(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_instr_i  (in_instr),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_instr_o (out_instr),
    .count_o     (count),
    .starve_o    (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fetched_instr_t mk(input logic [63:0] pc, input logic ex);
    fetched_instr_t f;
    f.pc       = pc;
    f.instr    = {pc[15:0], 16'h0013};
    f.ex_valid = ex;
    f.ex_cause = ex ? 4'h1 : 4'h0;
    return f;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fetched_instr_t exp_q [$];
    fetched_instr_t e;
    logic [63:0] seq_pc;

    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count",     count,     0);
    check("rst_starve",    starve,    0);
    check("rst_out_instr", out_instr, 0);
    rst_n = 1'b1;
    tick();

    // Fill with four entries; 0x1008 carries an exception
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = mk(64'h1000 + 64'(4 * i), i == 2);
      tick();
      check($sformatf("fill_count_%0d", i), count, 128'(i + 1));
      check($sformatf("fill_valid_%0d", i), out_valid, 1);
      check($sformatf("fill_head_%0d", i), out_instr, mk(64'h1000, 1'b0));
    end
    check("full_in_ready", in_ready, 0);
    in_instr = mk(64'h1010, 1'b0);
    tick();
    check("full_fifth_rejected", count, 4);
    check("full_starve", starve, 0);

    // Drain in order
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_head_%0d", i), out_instr, mk(64'h1000 + 64'(4 * i), i == 2));
      check($sformatf("drain_valid_%0d", i), out_valid, 1);
      if (i == 0) check("drain_full_ready_before", in_ready, 0);
      tick();
      if (i == 0) check("drain_ready_after_pop", in_ready, 1);
      check($sformatf("drain_count_%0d", i), count, 128'(3 - i));
    end
    check("drain_empty_valid", out_valid, 0);
    check("drain_last_starve", starve, 0);

    // Starvation: empty with ready for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("starve_%0d", i), starve, 1);
    end
    in_valid = 1'b1;
    in_instr = mk(64'h2000, 1'b0);
    tick();
    in_valid = 1'b0;
    check("starve_push_visible", out_instr, mk(64'h2000, 1'b0));
    check("starve_push_cycle", starve, 1);
    tick();
    check("starve_cleared", starve, 0);
    out_ready = 1'b0;
    tick();
    check("starve_idle", starve, 0);
    check("starve_empty_again", count, 0);

    // Streaming at occupancy 2 with pointer wrap
    seq_pc = 64'h3000;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_instr = mk(seq_pc, 1'b0);
      exp_q.push_back(in_instr);
      seq_pc += 4;
      tick();
    end
    check("stream_prefill_count", count, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_instr = mk(seq_pc, 1'b0);
      exp_q.push_back(in_instr);
      seq_pc += 4;
      e = exp_q.pop_front();
      check($sformatf("stream_head_%0d", i), out_instr, e);
      tick();
      check($sformatf("stream_count_%0d", i), count, 2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      check($sformatf("stream_tail_%0d", i), out_instr, e);
      tick();
    end
    check("stream_done_valid", out_valid, 0);
    out_ready = 1'b0;

    // Flush at occupancy 3 with push and pop offered
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = mk(64'h4000 + 64'(4 * i), 1'b0);
      tick();
    end
    check("flush_pre_count", count, 3);
    flush     = 1'b1;
    in_instr  = mk(64'hDEAD0, 1'b0);
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush_count",     count,     0);
    check("flush_valid",     out_valid, 0);
    check("flush_in_ready",  in_ready,  1);
    check("flush_starve",    starve,    0);
    in_valid = 1'b1;
    in_instr = mk(64'h5000, 1'b0);
    tick();
    in_valid = 1'b0;
    check("flush_repush_valid", out_valid, 1);
    check("flush_repush_data",  out_instr, mk(64'h5000, 1'b0));
    check("flush_repush_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("flush_drop_never_seen", out_valid, 0);

    // Asynchronous reset mid-cycle at occupancy 2
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_instr = mk(64'h6000 + 64'(4 * i), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    check("arst_pre_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",     out_valid, 0);
    check("arst_count",     count,     0);
    check("arst_in_ready",  in_ready,  1);
    check("arst_out_instr", out_instr, 0);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_instr = mk(64'h7000, 1'b0);
    tick();
    in_valid = 1'b0;
    check("arst_fresh_data",  out_instr, mk(64'h7000, 1'b0));
    check("arst_fresh_count", count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
